rat_intr_ctrl: RTL and testbench
================================

Name: rat_intr_ctrl

Overview:
- Multi-source interrupt controller for the RAT MCU.
- Collects up to NUM_SRC external interrupt requests, edge-detects them and latches them as pending.
- Applies a software mask and fixed priority, then drives the single INTR input of the MCU top.
- Software configures and acknowledges it through the MCU I/O port bus (PORT_ID / OUT_PORT / IO_STRB for writes, combinational read mux into IN_PORT).

Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..8.
- MASK_ADDR, 8'h20: R/W mask register port; bit=1 enables the source.
- PEND_ADDR, 8'h21: pending register port. Read returns pending; write is W1C.
- CLAIM_ADDR, 8'h22: write = claim; read returns the active vector.
- EOI_ADDR, 8'h23: write = end of interrupt.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IRQ  in  NUM_SRC  interrupt request lines; a rising edge raises a request.
- PORT_ID  in  8  I/O address from the MCU (IR[7:0]).
- OUT_PORT  in  8  I/O write data from the MCU (DX).
- IO_STRB  in  1  single-cycle I/O write strobe.
- RD_DATA  out  8  read data for the addressed register; 8'h00 when not addressed.
- RD_HIT  out  1  PORT_ID matches a readable address; selects RD_DATA onto IN_PORT.
- INTR  out  1  interrupt request to the MCU, ANDed with the I flag at the top level.
- ACTIVE_VEC  out  3  index of the claimed/in-service source (debug).

Behaviour:
- Reset: mask=0, pending=0, state=IDLE, INTR=0, ACTIVE_VEC=0, IRQ history regs=0. Takes effect immediately; an in-progress REQ/SERVICE is abandoned.
- Edge detect: irq_q registers IRQ. A rise is IRQ & ~irq_q and sets the pending bit in the next cycle. Unused bits (index ≥ NUM_SRC) read 0.
- eligible = pending & mask. Winner = lowest set index (bit 0 is highest priority).
- FSM is IDLE, REQ, SERVICE (enum in package).
  - IDLE: if eligible≠0, capture winner into ACTIVE_VEC → REQ. INTR goes high the same cycle the state enters REQ, i.e. 1 cycle after pending sets and 2 cycles after the IRQ edge.
  - REQ: INTR=1, held as a level until claim. A claim (IO_STRB & PORT_ID==CLAIM_ADDR) clears pending[ACTIVE_VEC] → SERVICE. The winner is frozen in REQ; a newly arrived higher-priority source does not preempt.
  - REQ, masked out: if the captured source is masked off or W1C-cleared before claim → IDLE, INTR=0, re-arbitrated next cycle.
  - SERVICE: INTR=0. An EOI write → IDLE. Nesting is not supported; new requests only accumulate in pending.
  - EOI in IDLE or REQ is ignored. A claim in IDLE or SERVICE is ignored.
- Writes:
  - MASK_ADDR loads OUT_PORT[NUM_SRC-1:0].
  - PEND_ADDR clears the bits written as 1.
  - On a same-cycle set (edge) and clear of the same bit, set wins.
- Reads (combinational from PORT_ID; no read side effects):
  - MASK_ADDR → mask.
  - PEND_ADDR → pending.
  - CLAIM_ADDR → {4'b0, state==SERVICE, ACTIVE_VEC}.
  - EOI_ADDR is not readable (RD_HIT=0).
- Duplicate addresses across parameters are illegal; flag with an elaboration assertion.

Optional Feature:
- Macro RAT_INTC_SYNC_EN.
- Defined: each IRQ passes through a 2-flop synchronizer before edge detect. Adds 2 cycles of latency (IRQ edge → INTR = 4 cycles). Synchronizer flops reset to 0.
- Undefined: IRQ is treated as synchronous to CLK; no synchronizer, latency as above.

Decomposition:
- Package rat_intc_pkg holds:
  - the intc_state_t enum (IDLE, REQ, SERVICE);
  - default port address constants;
  - the MAX_SRC=8 constant.
- Sub-module intc_edge_det (per-bit optional synchronizer plus rising-edge pulse, width parameter), instantiated once with width NUM_SRC.

Test Plan:
- Reset mid-REQ: pulse IRQ[2] with mask=8'h04, reach REQ, assert RESET → INTR=0, pending=0, mask=0 immediately.
- Basic flow: mask=8'hFF, pulse IRQ[3] → INTR=1 two cycles after the edge. Then:
  - read CLAIM_ADDR = 8'h03;
  - claim → INTR=0, pending=8'h00, CLAIM read = 8'h0B;
  - EOI → IDLE.
- Priority: mask=8'hFF, IRQ[5] and IRQ[1] rise in the same cycle → ACTIVE_VEC=1. Then:
  - after claim+EOI, INTR reasserts with ACTIVE_VEC=5;
  - pending=8'h20 before the second claim.
- Masking: mask=8'h00, pulse IRQ[0] → pending=8'h01, INTR stays 0. Write mask=8'h01 → INTR=1 two cycles later.
- W1C collision: with pending[4] set, write PEND_ADDR=8'h10 in the same cycle as a new IRQ[4] edge → pending[4] remains 1.
- Pending during SERVICE: in SERVICE for vec 0, pulse IRQ[0] → INTR stays 0. EOI → INTR=1 two cycles later with ACTIVE_VEC=0.

Source files
------------

// File: rtl/rat_intc_pkg.sv
// Shared types and constants for the RAT MCU interrupt controller.
// Holds the FSM state enum, default I/O port addresses and the source-count ceiling.
package rat_intc_pkg;

    localparam int unsigned MAX_SRC = 8;

    localparam logic [7:0] DEF_MASK_ADDR  = 8'h20;
    localparam logic [7:0] DEF_PEND_ADDR  = 8'h21;
    localparam logic [7:0] DEF_CLAIM_ADDR = 8'h22;
    localparam logic [7:0] DEF_EOI_ADDR   = 8'h23;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } intc_state_t;

    // Index of the lowest set bit; bit 0 carries the highest priority.
    function automatic logic [2:0] lowest_set(input logic [MAX_SRC-1:0] req);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intc_edge_det.sv
// Per-bit rising-edge detector for interrupt request lines.
// With RAT_INTC_SYNC_EN defined, each line first passes a 2-flop synchronizer.
module intc_edge_det #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] irq_q;

`ifdef RAT_INTC_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = din;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_q <= '0;
        end else begin
            irq_q <= src;
        end
    end

    assign rise = src & ~irq_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Multi-source interrupt controller: edge-latched pending bits, software mask, fixed
// priority and claim/EOI handshake on the MCU I/O port bus. Optional macro: RAT_INTC_SYNC_EN.
module rat_intr_ctrl
    import rat_intc_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 8,
    parameter logic [7:0]  MASK_ADDR  = DEF_MASK_ADDR,
    parameter logic [7:0]  PEND_ADDR  = DEF_PEND_ADDR,
    parameter logic [7:0]  CLAIM_ADDR = DEF_CLAIM_ADDR,
    parameter logic [7:0]  EOI_ADDR   = DEF_EOI_ADDR
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    output logic [7:0]         RD_DATA,
    output logic               RD_HIT,
    output logic               INTR,
    output logic [2:0]         ACTIVE_VEC
);

    if (NUM_SRC < 1 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
        $error("rat_intr_ctrl: NUM_SRC must be in 1..8");
    end

    if (MASK_ADDR == PEND_ADDR  || MASK_ADDR == CLAIM_ADDR || MASK_ADDR == EOI_ADDR ||
        PEND_ADDR == CLAIM_ADDR || PEND_ADDR == EOI_ADDR   || CLAIM_ADDR == EOI_ADDR)
    begin : g_dup_addr
        $error("rat_intr_ctrl: register port addresses must be distinct");
    end

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC-1:0] claim_clr;
    logic [MAX_SRC-1:0] elig_ext;
    logic [MAX_SRC-1:0] mask_ext;
    logic [MAX_SRC-1:0] pend_ext;
    logic [MAX_SRC-1:0] vec_onehot;
    intc_state_t        state_q, state_d;
    logic [2:0]         vec_q, vec_d;
    logic               wr_mask, wr_pend, wr_claim, wr_eoi;

    intc_edge_det #(
        .WIDTH (NUM_SRC)
    ) u_edge_det (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (IRQ),
        .rise  (rise)
    );

    assign wr_mask  = IO_STRB && (PORT_ID == MASK_ADDR);
    assign wr_pend  = IO_STRB && (PORT_ID == PEND_ADDR);
    assign wr_claim = IO_STRB && (PORT_ID == CLAIM_ADDR);
    assign wr_eoi   = IO_STRB && (PORT_ID == EOI_ADDR);

    assign eligible   = pend_q & mask_q;
    assign vec_onehot = MAX_SRC'(1) << vec_q;

    // Zero-extend the source-wide vectors so arbitration and reads work for any NUM_SRC.
    always_comb begin
        elig_ext = '0;
        mask_ext = '0;
        pend_ext = '0;
        elig_ext[NUM_SRC-1:0] = eligible;
        mask_ext[NUM_SRC-1:0] = mask_q;
        pend_ext[NUM_SRC-1:0] = pend_q;
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        claim_clr = '0;
        INTR      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    vec_d   = lowest_set(elig_ext);
                end
            end
            REQ: begin
                INTR = 1'b1;
                // Captured source withdrawn by mask or W1C: drop the request and re-arbitrate.
                if (!elig_ext[vec_q]) begin
                    state_d = IDLE;
                end else if (wr_claim) begin
                    state_d   = SERVICE;
                    claim_clr = vec_onehot[NUM_SRC-1:0];
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        w1c_clr = wr_pend ? OUT_PORT[NUM_SRC-1:0] : '0;
        mask_d  = wr_mask ? OUT_PORT[NUM_SRC-1:0] : mask_q;
        // A fresh edge overrides any same-cycle clear of the same bit.
        pend_d  = (pend_q & ~w1c_clr & ~claim_clr) | rise;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        RD_DATA = 8'h00;
        RD_HIT  = 1'b0;
        if (PORT_ID == MASK_ADDR) begin
            RD_HIT  = 1'b1;
            RD_DATA = mask_ext;
        end else if (PORT_ID == PEND_ADDR) begin
            RD_HIT  = 1'b1;
            RD_DATA = pend_ext;
        end else if (PORT_ID == CLAIM_ADDR) begin
            RD_HIT  = 1'b1;
            RD_DATA = {4'b0000, (state_q == SERVICE), vec_q};
        end
    end

    assign ACTIVE_VEC = vec_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Self-checking bench for rat_intr_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the controller.
module tb_rat_intr_ctrl;

`ifdef RAT_INTC_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int LAT = 2 + D;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IRQ;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] RD_DATA;
    logic       RD_HIT;
    logic       INTR;
    logic [2:0] ACTIVE_VEC;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    bit [7:0] m_mask, m_pend;
    bit       m_wait, m_serv;
    int       m_vec;
    bit [7:0] m_hist [1:3];

    rat_intr_ctrl #(
        .NUM_SRC (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IRQ        (IRQ),
        .PORT_ID    (PORT_ID),
        .OUT_PORT   (OUT_PORT),
        .IO_STRB    (IO_STRB),
        .RD_DATA    (RD_DATA),
        .RD_HIT     (RD_HIT),
        .INTR       (INTR),
        .ACTIVE_VEC (ACTIVE_VEC)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_wait = 0; m_serv = 0; m_vec = 0;
        for (int k = 1; k <= 3; k++) m_hist[k] = 0;
    endtask

    function automatic bit [7:0] hist_at(int k, bit [7:0] cur);
        return (k == 0) ? cur : m_hist[k];
    endfunction

    function automatic int first_one(bit [7:0] v);
        int i = 0;
        while (!v[i]) i++;
        return i;
    endfunction

    function automatic bit exp_hit(bit [7:0] id);
        return id == 8'h20 || id == 8'h21 || id == 8'h22;
    endfunction

    function automatic bit [7:0] exp_rd(bit [7:0] id);
        bit [2:0] v;
        v = 3'(m_vec);
        case (id)
            8'h20:   return m_mask;
            8'h21:   return m_pend;
            8'h22:   return {4'b0000, m_serv, v};
            default: return 8'h00;
        endcase
    endfunction

    // Advance one clock: predict the post-edge model state from pre-edge inputs.
    task automatic tick();
        bit [7:0] cur, rise, elig, n_pend, n_mask;
        bit       n_wait, n_serv, claim, eoi;
        int       n_vec;
        cur    = IRQ;
        rise   = hist_at(D, cur) & ~hist_at(D + 1, cur);
        elig   = m_pend & m_mask;
        claim  = IO_STRB && PORT_ID == 8'h22;
        eoi    = IO_STRB && PORT_ID == 8'h23;
        n_pend = m_pend; n_mask = m_mask; n_wait = m_wait; n_serv = m_serv; n_vec = m_vec;
        if (IO_STRB && PORT_ID == 8'h20) n_mask = OUT_PORT;
        if (IO_STRB && PORT_ID == 8'h21) n_pend = n_pend & ~OUT_PORT;
        if (!m_wait && !m_serv) begin
            if (elig != 0) begin
                n_wait = 1;
                n_vec  = first_one(elig);
            end
        end else if (m_wait) begin
            if (!elig[m_vec]) begin
                n_wait = 0;
            end else if (claim) begin
                n_wait = 0;
                n_serv = 1;
                n_pend[m_vec] = 0;
            end
        end else if (eoi) begin
            n_serv = 0;
        end
        n_pend = n_pend | rise;
        @(posedge CLK);
        #1;
        m_pend = n_pend; m_mask = n_mask; m_wait = n_wait; m_serv = n_serv; m_vec = n_vec;
        m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = cur;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic wr(input bit [7:0] a, input bit [7:0] d);
        PORT_ID = a; OUT_PORT = d; IO_STRB = 1'b1;
        tick();
        IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    endtask

    task automatic pulse(input bit [7:0] b);
        IRQ = b;
        tick();
        IRQ = 8'h00;
    endtask

    task automatic do_reset();
        IRQ = 8'h00; IO_STRB = 1'b0; PORT_ID = 8'h00;
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL reset_intr got %b want 0", INTR); end
        checks++; if (ACTIVE_VEC !== 3'd0) begin errors++; $display("FAIL reset_vec got %0d want 0", ACTIVE_VEC); end
        PORT_ID = 8'h20; #1;
        checks++; if (RD_DATA !== 8'h00 || RD_HIT !== 1'b1) begin errors++; $display("FAIL reset_mask got %h/%b want 00/1", RD_DATA, RD_HIT); end
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL reset_pend got %h want 00", RD_DATA); end
        PORT_ID = 8'h23; #1;
        checks++; if (RD_HIT !== 1'b0 || RD_DATA !== 8'h00) begin errors++; $display("FAIL eoi_not_readable got %h/%b want 00/0", RD_DATA, RD_HIT); end
        PORT_ID = 8'h55; #1;
        checks++; if (RD_HIT !== 1'b0 || RD_DATA !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h/%b want 00/0", RD_DATA, RD_HIT); end
        PORT_ID = 8'h00;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic();
        wr(8'h20, 8'hFF);
        pulse(8'h08);
        ticks(LAT - 2);
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL basic_early_intr got %b want 0", INTR); end
        tick();
        checks++; if (INTR !== 1'b1 || ACTIVE_VEC !== 3'd3) begin errors++; $display("FAIL basic_intr got %b/%0d want 1/3", INTR, ACTIVE_VEC); end
        PORT_ID = 8'h22; #1;
        checks++; if (RD_DATA !== 8'h03) begin errors++; $display("FAIL basic_claim_rd got %h want 03", RD_DATA); end
        wr(8'h22, 8'h00);
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL basic_claim_intr got %b want 0", INTR); end
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL basic_claim_pend got %h want 00", RD_DATA); end
        PORT_ID = 8'h22; #1;
        checks++; if (RD_DATA !== 8'h0B) begin errors++; $display("FAIL basic_service_rd got %h want 0B", RD_DATA); end
        wr(8'h23, 8'h00);
        PORT_ID = 8'h22; #1;
        checks++; if (RD_DATA[3] !== 1'b0 || INTR !== 1'b0) begin errors++; $display("FAIL basic_eoi got %h/%b want bit3=0/0", RD_DATA, INTR); end
        PORT_ID = 8'h00;
    endtask

    task automatic test_priority();
        pulse(8'h22);
        ticks(LAT - 1);
        checks++; if (INTR !== 1'b1 || ACTIVE_VEC !== 3'd1) begin errors++; $display("FAIL prio_first got %b/%0d want 1/1", INTR, ACTIVE_VEC); end
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h22) begin errors++; $display("FAIL prio_pend_both got %h want 22", RD_DATA); end
        wr(8'h22, 8'h00);
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h20) begin errors++; $display("FAIL prio_pend_after_claim got %h want 20", RD_DATA); end
        wr(8'h23, 8'h00);
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL prio_eoi_intr got %b want 0", INTR); end
        tick();
        checks++; if (INTR !== 1'b1 || ACTIVE_VEC !== 3'd5) begin errors++; $display("FAIL prio_second got %b/%0d want 1/5", INTR, ACTIVE_VEC); end
        wr(8'h22, 8'h00);
        wr(8'h23, 8'h00);
    endtask

    task automatic test_masking();
        wr(8'h20, 8'h00);
        pulse(8'h01);
        ticks(LAT + 1);
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL mask_intr_off got %b want 0", INTR); end
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h01) begin errors++; $display("FAIL mask_pend got %h want 01", RD_DATA); end
        wr(8'h20, 8'h01);
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL mask_enable_early got %b want 0", INTR); end
        tick();
        checks++; if (INTR !== 1'b1 || ACTIVE_VEC !== 3'd0) begin errors++; $display("FAIL mask_enable got %b/%0d want 1/0", INTR, ACTIVE_VEC); end
        wr(8'h22, 8'h00);
        wr(8'h23, 8'h00);
    endtask

    task automatic test_w1c_collision();
        wr(8'h20, 8'h00);
        pulse(8'h10);
        ticks(D + 2);
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h10) begin errors++; $display("FAIL w1c_setup got %h want 10", RD_DATA); end
        IRQ = 8'h10;
        ticks(D);
        wr(8'h21, 8'h10);
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h10) begin errors++; $display("FAIL w1c_collision got %h want 10", RD_DATA); end
        ticks(D + 1);
        wr(8'h21, 8'h10);
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL w1c_clear got %h want 00", RD_DATA); end
        PORT_ID = 8'h00;
        IRQ = 8'h00;
        ticks(D + 2);
    endtask

    task automatic test_service_pending();
        wr(8'h20, 8'hFF);
        pulse(8'h01);
        ticks(LAT - 1);
        checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL svc_first got %b want 1", INTR); end
        wr(8'h22, 8'h00);
        pulse(8'h01);
        ticks(LAT);
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL svc_no_nest got %b want 0", INTR); end
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h01) begin errors++; $display("FAIL svc_pend got %h want 01", RD_DATA); end
        PORT_ID = 8'h22; #1;
        checks++; if (RD_DATA !== 8'h08) begin errors++; $display("FAIL svc_claim_rd got %h want 08", RD_DATA); end
        wr(8'h23, 8'h00);
        checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL svc_eoi_early got %b want 0", INTR); end
        tick();
        checks++; if (INTR !== 1'b1 || ACTIVE_VEC !== 3'd0) begin errors++; $display("FAIL svc_reassert got %b/%0d want 1/0", INTR, ACTIVE_VEC); end
        wr(8'h22, 8'h00);
        wr(8'h23, 8'h00);
    endtask

    task automatic test_reset_mid_req();
        wr(8'h20, 8'h04);
        pulse(8'h04);
        ticks(LAT - 1);
        checks++; if (INTR !== 1'b1 || ACTIVE_VEC !== 3'd2) begin errors++; $display("FAIL rst_req_setup got %b/%0d want 1/2", INTR, ACTIVE_VEC); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (INTR !== 1'b0 || ACTIVE_VEC !== 3'd0) begin errors++; $display("FAIL rst_req_intr got %b/%0d want 0/0", INTR, ACTIVE_VEC); end
        PORT_ID = 8'h21; #1;
        checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL rst_req_pend got %h want 00", RD_DATA); end
        PORT_ID = 8'h20; #1;
        checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL rst_req_mask got %h want 00", RD_DATA); end
        do_reset();
    endtask

    task automatic test_random();
        bit [31:0] r;
        int        sel;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom;
            IRQ = IRQ ^ (r[7:0] & r[15:8] & r[23:16]);
            sel = $urandom_range(0, 6);
            PORT_ID  = (sel < 4) ? 8'(8'h20 + sel) : 8'($urandom_range(0, 255));
            OUT_PORT = 8'($urandom);
            IO_STRB  = ($urandom_range(0, 3) == 0);
            #1;
            checks++; if (INTR !== m_wait) begin errors++; $display("FAIL rand_intr cyc %0d got %b want %b", n, INTR, m_wait); end
            checks++; if (ACTIVE_VEC !== 3'(m_vec)) begin errors++; $display("FAIL rand_vec cyc %0d got %0d want %0d", n, ACTIVE_VEC, m_vec); end
            checks++; if (RD_HIT !== exp_hit(PORT_ID)) begin errors++; $display("FAIL rand_hit cyc %0d id %h got %b want %b", n, PORT_ID, RD_HIT, exp_hit(PORT_ID)); end
            checks++; if (RD_DATA !== exp_rd(PORT_ID)) begin errors++; $display("FAIL rand_rd cyc %0d id %h got %h want %h", n, PORT_ID, RD_DATA, exp_rd(PORT_ID)); end
            tick();
        end
        IO_STRB = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; IRQ = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_w1c_collision();
        test_service_pending();
        test_reset_mid_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
